shreg_ser_ctrl: RTL and testbench
=================================

# shreg_ser_ctrl

Serializer controller wrapped around a parallel-load, left-shifting shift register. It accepts a parallel word through a valid/ready handshake and shifts it out MSB first on `sout`, holding each bit for a programmable number of clocks. At the same time it shifts `sin` into the LSB, so a full-duplex received word is available when the frame ends. It sits between a parallel producer/consumer and a bit-serial link.

## Interface

- `WIDTH`, default 8, word length in bits; must be ≥ 2.
- `DIV`, default 4, clock cycles per bit; must be ≥ 1.

- `clk`  in  1  sole clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `tx_data`  in  WIDTH  word to transmit; sampled on handshake.
- `tx_valid`  in  1  producer has a word.
- `tx_ready`  out  1  controller can accept a word; high only in IDLE.
- `sin`  in  1  serial input; sampled at the last cycle of each bit period.
- `sout`  out  1  serial output; shift register MSB while `frame`=1, else 0.
- `frame`  out  1  high for exactly WIDTH×DIV cycles per word.
- `bit_strobe`  out  1  one-cycle pulse on the first cycle of each bit period.
- `rx_data`  out  WIDTH  last received word; holds until the next frame completes.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` updates.

## Operation

- Internal state:
  - shift register `sr[WIDTH-1:0]`
  - bit counter `bit_cnt`, range 0..WIDTH-1
  - divider counter `div_cnt`, range 0..DIV-1
  - FSM with three states: IDLE, SHIFT, DONE.
- IDLE:
  - `tx_ready`=1.
  - On `tx_valid && tx_ready` at an edge: `sr` ← `tx_data`, `bit_cnt` ← 0, `div_cnt` ← 0, go to SHIFT.
- SHIFT:
  - `frame`=1, `tx_ready`=0.
  - `bit_strobe` = (`div_cnt`==0).
  - If `div_cnt` < DIV-1: `div_cnt` increments and `sr` holds.
  - If `div_cnt` == DIV-1:
    - `sr` ← {`sr[WIDTH-2:0]`, `sin`} and `div_cnt` ← 0.
    - If `bit_cnt` == WIDTH-1: `rx_data` ← {`sr[WIDTH-2:0]`, `sin`}, go to DONE.
    - Else `bit_cnt` increments.
- DONE:
  - Lasts one cycle, with `rx_valid`=1, `frame`=0, `tx_ready`=0.
  - Always returns to IDLE.
- `tx_valid` and `tx_data` are ignored outside IDLE; a producer holding `tx_valid` high is served again in the next IDLE cycle.
- `tx_ready` and `frame` are decoded from the state. `sout` = `frame` ? `sr[WIDTH-1]` : 0. These outputs have no extra register stage.
- Counters never wrap past their bounds. With DIV=1, `div_cnt` is constantly 0 and `bit_strobe`=1 on every SHIFT cycle.
- Reset:
  - Values: state IDLE, `sr`=0, `bit_cnt`=0, `div_cnt`=0, `rx_data`=0.
  - Outputs after reset: `tx_ready`=1, `frame`=0, `sout`=0, `bit_strobe`=0, `rx_valid`=0.
  - Reset mid-frame aborts the word. It produces no `rx_valid`, `rx_data` becomes 0, and IDLE follows in the next cycle.
  - Reset has priority over the handshake in the same cycle.

## Timing

- Handshake accepted at edge E0:
  - `frame` is high in cycles 1 .. WIDTH×DIV after E0.
  - `rx_valid` is high in cycle WIDTH×DIV+1.
  - `tx_ready` is high again in cycle WIDTH×DIV+2.
- Bit i (i=0 is the MSB) is driven on `sout` in cycles i×DIV+1 .. (i+1)×DIV.
- `sin` for bit i is sampled at the edge ending cycle (i+1)×DIV. It lands in `rx_data[WIDTH-1-i]`.
- Back-to-back throughput is one word per WIDTH×DIV+2 cycles. `frame` has a minimum 2-cycle low gap between words (DONE plus IDLE).
- Latency from accept to `rx_valid` is WIDTH×DIV+1 cycles.

## Test plan

- WIDTH=8, DIV=1, `sin` tied to `sout`, send 0xA5 → `sout` = 1,0,1,0,0,1,0,1 in cycles 1..8; `rx_valid` in cycle 9 with `rx_data`=0xA5; `tx_ready` returns in cycle 10.
- WIDTH=8, DIV=4, `sin`=1 constant, send 0x00 → `frame` high for 32 cycles; `bit_strobe` in cycles 1,5,…,29; `sout`=0 throughout; `rx_data`=0xFF in cycle 33.
- `tx_valid` held high continuously with data 0x3C, then 0xC3 (DIV=1) → second word accepted in the IDLE cycle 10; second frame in cycles 11..18; `rx_valid` in cycles 9 and 19.
- `tx_valid` pulsed with 0xFF in cycle 4 of a frame (DIV=2) → ignored; exactly one frame observed; `rx_data` reflects only the first word's loopback.
- `rst` asserted in cycle 5 of a DIV=1 frame → next cycle: `frame`=0, `sout`=0, `tx_ready`=1, `rx_data`=0; no `rx_valid` pulse ever appears for that word.
- `rst` and `tx_valid` high in the same cycle → no frame starts; `tx_ready`=1 afterwards.

Source files
------------

// File: rtl/shreg_ser_ctrl.sv
// shreg_ser_ctrl: valid/ready serializer shifting a word out MSB first while shifting sin into the LSB
module shreg_ser_ctrl #(
   parameter int WIDTH = 8,
   parameter int DIV   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] tx_data,
   input  logic             tx_valid,
   output logic             tx_ready,
   input  logic             sin,
   output logic             sout,
   output logic             frame,
   output logic             bit_strobe,
   output logic [WIDTH-1:0] rx_data,
   output logic             rx_valid
);
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] sr;
   logic [BW-1:0]    bit_cnt;
   logic [DW-1:0]    div_cnt;
   logic [WIDTH-1:0] sr_next;
   assign sr_next    = {sr[WIDTH-2:0], sin};
   assign tx_ready   = state == IDLE;
   assign frame      = state == SHIFT;
   assign rx_valid   = state == DONE;
   assign bit_strobe = frame && div_cnt == '0;
   assign sout       = frame ? sr[WIDTH-1] : 1'b0;
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sr      <= '0;
         bit_cnt <= '0;
         div_cnt <= '0;
         rx_data <= '0;
      end else begin
         case (state)
            IDLE: if (tx_valid) begin
               sr      <= tx_data;
               bit_cnt <= '0;
               div_cnt <= '0;
               state   <= SHIFT;
            end
            SHIFT: if (div_cnt == DIV_LAST) begin
               sr      <= sr_next;
               div_cnt <= '0;
               if (bit_cnt == BIT_LAST) begin
                  rx_data <= sr_next;
                  state   <= DONE;
               end else begin
                  bit_cnt <= bit_cnt + 1'b1;
               end
            end else begin
               div_cnt <= div_cnt + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_shreg_ser_ctrl.sv
// tb_shreg_ser_ctrl: directed checks on DIV=1 (loopback), DIV=2 (loopback) and DIV=4 (sin=1) instances
module tb_shreg_ser_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;
   logic [7:0] d1, d2, d4, rx1, rx2, rx4;
   logic v1, v2, v4, sin1, sin2, sin4;
   logic rdy1, rdy2, rdy4, so1, so2, so4, fr1, fr2, fr4, bs1, bs2, bs4, rxv1, rxv2, rxv4;
   assign sin1 = so1;
   assign sin2 = so2;
   shreg_ser_ctrl #(.WIDTH(8), .DIV(1)) u1 (.clk(clk), .rst(rst), .tx_data(d1), .tx_valid(v1), .tx_ready(rdy1),
      .sin(sin1), .sout(so1), .frame(fr1), .bit_strobe(bs1), .rx_data(rx1), .rx_valid(rxv1));
   shreg_ser_ctrl #(.WIDTH(8), .DIV(2)) u2 (.clk(clk), .rst(rst), .tx_data(d2), .tx_valid(v2), .tx_ready(rdy2),
      .sin(sin2), .sout(so2), .frame(fr2), .bit_strobe(bs2), .rx_data(rx2), .rx_valid(rxv2));
   shreg_ser_ctrl #(.WIDTH(8), .DIV(4)) u4 (.clk(clk), .rst(rst), .tx_data(d4), .tx_valid(v4), .tx_ready(rdy4),
      .sin(sin4), .sout(so4), .frame(fr4), .bit_strobe(bs4), .rx_data(rx4), .rx_valid(rxv4));
   typedef struct {
      logic       frame, sout, bstr, rxv, rdy;
      logic [7:0] rx;
   } vec_t;
   vec_t tab[10];
   int total = 0;
   int passed = 0;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
      else passed++;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      int fcnt, rcnt;
      tab[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      tab[1] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
      tab[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      tab[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
      tab[4] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
      tab[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      tab[6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
      tab[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      tab[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5};
      tab[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5};
      {d1, d2, d4, v1, v2, v4, sin4} = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_ready", rdy1, 1);
      chk("rst_frame", fr1, 0);
      chk("rst_sout", so1, 0);
      chk("rst_strobe", bs1, 0);
      chk("rst_rxvalid", rxv1, 0);
      chk("rst_rxdata", rx1, 0);
      chk("rst_ready4", rdy4, 1);
      // A5 loopback at DIV=1, cycle-by-cycle against the table
      d1 = 8'hA5;
      v1 = 1'b1;
      tick();
      v1 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         chk($sformatf("t1_frame_c%0d", k + 1), fr1, tab[k].frame);
         chk($sformatf("t1_sout_c%0d", k + 1), so1, tab[k].sout);
         chk($sformatf("t1_strobe_c%0d", k + 1), bs1, tab[k].bstr);
         chk($sformatf("t1_rxv_c%0d", k + 1), rxv1, tab[k].rxv);
         chk($sformatf("t1_rdy_c%0d", k + 1), rdy1, tab[k].rdy);
         chk($sformatf("t1_rx_c%0d", k + 1), rx1, tab[k].rx);
         tick();
      end
      // 0x00 at DIV=4 with sin held high
      sin4 = 1'b1;
      d4 = 8'h00;
      v4 = 1'b1;
      tick();
      v4 = 1'b0;
      for (int k = 1; k <= 34; k++) begin
         chk($sformatf("t2_frame_c%0d", k), fr4, k <= 32);
         chk($sformatf("t2_strobe_c%0d", k), bs4, k <= 32 && (k - 1) % 4 == 0);
         chk($sformatf("t2_sout_c%0d", k), so4, 0);
         chk($sformatf("t2_rxv_c%0d", k), rxv4, k == 33);
         if (k == 33) chk("t2_rx", rx4, 8'hFF);
         if (k == 34) chk("t2_rdy", rdy4, 1);
         tick();
      end
      // tx_valid held high: 3C then C3 back to back at DIV=1
      d1 = 8'h3C;
      v1 = 1'b1;
      tick();
      d1 = 8'hC3;
      for (int k = 1; k <= 20; k++) begin
         chk($sformatf("t3_frame_c%0d", k), fr1, (k >= 1 && k <= 8) || (k >= 11 && k <= 18));
         chk($sformatf("t3_rxv_c%0d", k), rxv1, k == 9 || k == 19);
         chk($sformatf("t3_rdy_c%0d", k), rdy1, k == 10 || k == 20);
         if (k == 9) chk("t3_rx1", rx1, 8'h3C);
         if (k == 19) chk("t3_rx2", rx1, 8'hC3);
         if (k == 11) v1 = 1'b0;
         tick();
      end
      // stray tx_valid mid-frame at DIV=2 is ignored
      d2 = 8'h96;
      v2 = 1'b1;
      tick();
      v2 = 1'b0;
      fcnt = 0;
      rcnt = 0;
      for (int k = 1; k <= 24; k++) begin
         if (k == 4) begin
            d2 = 8'hFF;
            v2 = 1'b1;
         end
         if (k == 5) v2 = 1'b0;
         fcnt += int'(fr2);
         rcnt += int'(rxv2);
         if (k == 17) chk("t4_rx", rx2, 8'h96);
         if (k == 18) chk("t4_rdy", rdy2, 1);
         tick();
      end
      chk("t4_frame_cycles", fcnt, 16);
      chk("t4_rxvalid_count", rcnt, 1);
      chk("t4_rx_final", rx2, 8'h96);
      // reset in cycle 5 of a DIV=1 frame
      d1 = 8'hF0;
      v1 = 1'b1;
      tick();
      v1 = 1'b0;
      for (int k = 1; k < 5; k++) tick();
      chk("t5_frame_c5", fr1, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("t5_frame", fr1, 0);
      chk("t5_sout", so1, 0);
      chk("t5_rdy", rdy1, 1);
      chk("t5_rx", rx1, 0);
      rcnt = 0;
      for (int k = 0; k < 10; k++) begin
         rcnt += int'(rxv1);
         tick();
      end
      chk("t5_no_rxvalid", rcnt, 0);
      // reset and tx_valid together
      d1 = 8'h55;
      v1 = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      v1 = 1'b0;
      chk("t6_frame", fr1, 0);
      chk("t6_rdy", rdy1, 1);
      tick();
      chk("t6_frame_next", fr1, 0);
      chk("t6_rdy_next", rdy1, 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
